// File: rtl/test_ctrl_pkg.sv
// test_ctrl_pkg -- shared definitions for the test controller:
// FSM state encoding, Wishbone register offsets, STATUS bit positions
// and the byte-enable merge helper used for signature registers.
package test_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_e;

    localparam logic [7:0] OFF_TOHOST    = 8'h00;
    localparam logic [7:0] OFF_CYCLES    = 8'h04;
    localparam logic [7:0] OFF_WDOG_KICK = 8'h08;
    localparam logic [7:0] OFF_STATUS    = 8'h0C;
    localparam logic [7:0] OFF_SIG_BASE  = 8'h10;

    localparam int STATUS_DONE_BIT    = 0;
    localparam int STATUS_PASS_BIT    = 1;
    localparam int STATUS_TIMEOUT_BIT = 2;

    // Replace only the bytes whose enable is set.
    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  sel
    );
        logic [31:0] mask;
        mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
        return (old_word & ~mask) | (new_word & mask);
    endfunction

endpackage

// File: rtl/test_ctrl_if.sv
// test_ctrl_if -- Wishbone classic slave bus bundle for test_ctrl.
// The slave modport is used by the controller, master by the host side.
interface test_ctrl_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [7:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        output wb_dat_o, wb_ack_o
    );

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        input  wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/test_ctrl_wdog.sv
// test_ctrl_wdog -- watchdog counter for test_ctrl (built only when
// TEST_CTRL_WDOG_EN is defined). Counts enabled cycles since the last
// clear; expire is raised in the cycle the count sits at TIMEOUT_CYCLES-1,
// unless a clear arrives in that same cycle.
module test_ctrl_wdog #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int              CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_r;

    // Count enabled cycles, restart on clear, park at the limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (enable && (count_r != LIMIT)) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expire = enable && !clear && (count_r == LIMIT);

endmodule

// File: rtl/test_ctrl.sv
// test_ctrl -- simulation test controller with a Wishbone classic slave.
// Software reports its verdict through TOHOST, the controller tracks a
// free-running cycle count and up to NUM_SIG signature registers.
// Optional watchdog: define TEST_CTRL_WDOG_EN to build it in; without it
// the TIMEOUT state is never entered and o_timeout is tied low.
module test_ctrl
    import test_ctrl_pkg::*;
#(
    parameter int NUM_SIG        = 4,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int CYC_W          = 32
) (
    input  logic        clk,
    input  logic        reset,
    test_ctrl_if.slave  wb,
    output logic        o_done,
    output logic        o_pass,
    output logic        o_timeout,
    output logic [30:0] o_fail_code
);

    state_e             state_r;
    state_e             state_nxt_s;
    logic               ack_r;
    logic [31:0]        dat_r;
    logic [CYC_W-1:0]   cycles_r;
    logic [31:0]        sig_r [NUM_SIG];
    logic [30:0]        fail_code_r;
    logic               done_r;
    logic               pass_r;
    logic               timeout_s;

    logic               req_s;
    logic               wr_req_s;
    logic               rd_req_s;
    logic [5:0]         word_s;
    logic [5:0]         sig_off_s;
    logic               sig_hit_s;
    logic               wr_tohost_s;
    logic               tohost_go_s;
    logic               wdog_expire_s;
    logic [31:0]        rd_data_s;
    logic               unused_adr_s;

    // A new transfer is accepted only when no ack is outstanding, so ack
    // can never be high on two consecutive cycles.
    assign req_s     = wb.wb_cyc_i & wb.wb_stb_i & ~ack_r;
    assign wr_req_s  = req_s & wb.wb_we_i;
    assign rd_req_s  = req_s & ~wb.wb_we_i;
    assign word_s    = wb.wb_adr_i[7:2];
    assign sig_off_s = word_s - OFF_SIG_BASE[7:2];
    assign sig_hit_s = (word_s >= OFF_SIG_BASE[7:2]) &&
                       (32'(sig_off_s) < 32'(NUM_SIG));

    assign wr_tohost_s = wr_req_s && (word_s == OFF_TOHOST[7:2]) &&
                         (wb.wb_sel_i != 4'd0);
    assign tohost_go_s = wr_tohost_s && wb.wb_dat_i[0] && (state_r == ST_RUN);

    // Byte-lane bits carry no information for word registers.
    assign unused_adr_s = ^wb.wb_adr_i[1:0];

`ifdef TEST_CTRL_WDOG_EN
    logic wr_kick_s;
    logic wdog_clear_s;
    logic timeout_r;

    assign wr_kick_s    = wr_req_s && (word_s == OFF_WDOG_KICK[7:2]) &&
                          (wb.wb_sel_i != 4'd0);
    assign wdog_clear_s = wr_kick_s | wr_tohost_s;

    test_ctrl_wdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (wdog_clear_s),
        .enable (state_r == ST_RUN),
        .expire (wdog_expire_s)
    );

    // Timeout flag follows the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_r <= 1'b0;
        end else begin
            timeout_r <= (state_nxt_s == ST_TIMEOUT);
        end
    end

    assign timeout_s = timeout_r;
`else
    assign wdog_expire_s = 1'b0;
    assign timeout_s     = 1'b0;
`endif

    // Verdict FSM: a TOHOST verdict takes priority over watchdog expiry.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (tohost_go_s) begin
                    if (wb.wb_dat_i == 32'd1) begin
                        state_nxt_s = ST_PASS;
                    end else begin
                        state_nxt_s = ST_FAIL;
                    end
                end else if (wdog_expire_s) begin
                    state_nxt_s = ST_TIMEOUT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_PASS, ST_FAIL, ST_TIMEOUT: state_nxt_s = state_r;
            default: state_nxt_s = ST_RUN;
        endcase
    end

    // State register, registered verdict outputs and latched fail code.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_RUN;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            fail_code_r <= 31'd0;
        end else begin
            state_r <= state_nxt_s;
            done_r  <= (state_nxt_s != ST_RUN);
            pass_r  <= (state_nxt_s == ST_PASS);
            if (tohost_go_s && (wb.wb_dat_i != 32'd1)) begin
                fail_code_r <= wb.wb_dat_i[31:1];
            end else begin
                fail_code_r <= fail_code_r;
            end
        end
    end

    // Cycle counter runs only while the test is still running.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycles_r <= {CYC_W{1'b0}};
        end else if (state_r == ST_RUN) begin
            cycles_r <= cycles_r + CYC_W'(1);
        end else begin
            cycles_r <= cycles_r;
        end
    end

    // Signature registers with per-byte write enables, live in every state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SIG; i++) begin
                sig_r[i] <= 32'd0;
            end
        end else begin
            for (int i = 0; i < NUM_SIG; i++) begin
                if (wr_req_s && sig_hit_s && (sig_off_s == 6'(i))) begin
                    sig_r[i] <= byte_merge(sig_r[i], wb.wb_dat_i, wb.wb_sel_i);
                end else begin
                    sig_r[i] <= sig_r[i];
                end
            end
        end
    end

    // Read multiplexer; write-only and unmapped offsets read as zero.
    always_comb begin
        rd_data_s = 32'd0;
        case (word_s)
            OFF_CYCLES[7:2]: rd_data_s = 32'(cycles_r);
            OFF_STATUS[7:2]: begin
                rd_data_s[STATUS_DONE_BIT]    = done_r;
                rd_data_s[STATUS_PASS_BIT]    = pass_r;
                rd_data_s[STATUS_TIMEOUT_BIT] = timeout_s;
            end
            default: begin
                for (int i = 0; i < NUM_SIG; i++) begin
                    if (sig_hit_s && (sig_off_s == 6'(i))) begin
                        rd_data_s = sig_r[i];
                    end else begin
                        rd_data_s = rd_data_s;
                    end
                end
            end
        endcase
    end

    // Single-cycle ack with registered read data presented alongside it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_r <= 1'b0;
            dat_r <= 32'd0;
        end else begin
            ack_r <= req_s;
            if (rd_req_s) begin
                dat_r <= rd_data_s;
            end else begin
                dat_r <= 32'd0;
            end
        end
    end

    assign wb.wb_ack_o = ack_r;
    assign wb.wb_dat_o = dat_r;
    assign o_done      = done_r;
    assign o_pass      = pass_r;
    assign o_timeout   = timeout_s;
    assign o_fail_code = fail_code_r;

endmodule

// File: doc/test_ctrl.md
TEST_CTRL -- requirements
Module: test_ctrl

Interface
REQ-001 Parameter NUM_SIG, default 4, number of 32-bit signature registers (1..16).
REQ-002 Parameter TIMEOUT_CYCLES, default 100000, watchdog limit in clk cycles (>=2).
REQ-003 Parameter CYC_W, default 32, cycle-counter width (16..64); reads return the low 32 bits.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone classic slave controls.
REQ-007 wb_adr_i  in  8  byte address; bits [1:0] are ignored.
REQ-008 wb_dat_i  in  32  write data.
REQ-009 wb_sel_i  in  4  byte enables.
REQ-010 wb_dat_o  out  32  read data.
REQ-011 wb_ack_o  out  1  transfer acknowledge.
REQ-012 o_done  out  1  test has ended (pass, fail or timeout).
REQ-013 o_pass  out  1  test passed.
REQ-014 o_timeout  out  1  watchdog expired.
REQ-015 o_fail_code  out  31  failure code latched from TOHOST.

Function
REQ-016 Register map: 0x00 TOHOST (W, RAZ); 0x04 CYCLES (RO); 0x08 WDOG_KICK (W, RAZ); 0x0C STATUS (RO: [0] done, [1] pass, [2] timeout, [31:3] zero); 0x10+4*i SIG[i] (RW). All other offsets read 0, are acked, and ignore writes.
REQ-017 wb_ack_o shall pulse for exactly one cycle, the cycle after wb_cyc_i&wb_stb_i is sampled high with ack low; it is never asserted on two consecutive cycles.
REQ-018 Read data shall be registered and valid in the ack cycle.
REQ-019 SIG writes shall honour wb_sel_i per byte; TOHOST and WDOG_KICK writes act when wb_sel_i != 0 and use all 32 data bits.
REQ-020 FSM states: RUN (after reset), PASS, FAIL, TIMEOUT. PASS, FAIL and TIMEOUT are terminal until reset.
REQ-021 TOHOST write in RUN with data[0]=1: data==1 gives PASS; otherwise FAIL with o_fail_code=data[31:1]. Writes with data[0]=0 are ignored.
REQ-022 Outputs: o_done=1 in any terminal state; o_pass=1 only in PASS; o_timeout=1 only in TIMEOUT. All update on the edge after the causing write or expiry.
REQ-023 CYCLES shall increment every cycle in RUN, wrap modulo 2^CYC_W, and freeze in terminal states.
REQ-024 The watchdog counter is cleared on reset, on a WDOG_KICK write, and on any TOHOST write. Otherwise it increments in RUN. When it reaches TIMEOUT_CYCLES-1 in RUN, the next state is TIMEOUT.
REQ-025 If a TOHOST write and watchdog expiry occur in the same cycle, the TOHOST result wins.
REQ-026 In terminal states, TOHOST and WDOG_KICK writes are acked and ignored; SIG writes and all reads still function.

Reset
REQ-027 Reset shall drive: state RUN, wb_ack_o 0, wb_dat_o 0, o_done 0, o_pass 0, o_timeout 0, o_fail_code 0, CYCLES 0, watchdog 0, all SIG 0.
REQ-028 Reset asserted mid-transfer shall drop ack immediately. The interrupted write shall have no effect.

Configuration
REQ-029 With TEST_CTRL_WDOG_EN defined, the watchdog exists as specified.
REQ-030 Without TEST_CTRL_WDOG_EN: no watchdog logic is present, TIMEOUT is unreachable, o_timeout is tied 0, and WDOG_KICK writes are acked and ignored.

Structure
REQ-031 Package test_ctrl_pkg shall hold the FSM state enum, the register offset constants and the STATUS bit positions.
REQ-032 Sub-module test_ctrl_wdog shall contain the watchdog counter, with inputs clear/enable and output expire; it is instantiated only under TEST_CTRL_WDOG_EN.

Verification (NUM_SIG=4, TIMEOUT_CYCLES=16, watchdog enabled unless noted)
REQ-033 Write 0x00000001 to 0x00 -> ack 1 cycle later; o_done=1, o_pass=1 next edge; STATUS reads 0x3.
REQ-034 Write 0x0000000B to 0x00 -> o_done=1, o_pass=0, o_fail_code=5; a later write of 1 is ignored.
REQ-035 No writes after reset -> o_timeout=1, o_done=1 after 16 cycles; CYCLES frozen at 16. A kick every 10 cycles keeps state RUN for 200 cycles.
REQ-036 Write 0xAABBCCDD to SIG[2] with sel=0b0101, starting from 0 -> readback 0x00BB00DD; read of 0x40 returns 0.
REQ-037 TOHOST write of 1 in the same cycle as watchdog expiry -> state PASS, o_timeout=0.
REQ-038 Reset mid-write to SIG[0] -> ack 0 during reset; SIG[0] reads 0 after release. Build without TEST_CTRL_WDOG_EN -> no timeout after 1000 idle cycles.
